gcd_seq_ctrl: RTL and testbench

GCD_SEQ_CTRL -- requirements
Module: gcd_seq_ctrl

---
 rtl/gcd_seq_ctrl.sv | 117 +++++++++++
 tb/tb_gcd_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_seq_ctrl.sv
// Purpose : sequential subtractive GCD controller; A on the start cycle, B on the next cycle of data_in.
// Latency : start sampled at edge k, N subtractions -> done high in the cycle after edge k+N+2.
// Backpr. : none; start is ignored while busy (no queuing), abort cancels LOAD_B/CMP silently.
// Ports   : clk, rst (sync, active-high), start, abort, data_in[WIDTH] -> busy, done (1-cycle pulse),
//           result[WIDTH], iter_cnt[16], zero_flag (all held from the last completed computation).
module gcd_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      iter_cnt,
  output logic             zero_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_CMP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [15:0]      cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [15:0]      iter_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  // Saturating increment of the working iteration counter.
  logic [15:0] cnt_inc_d;
  assign cnt_inc_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      iter_q   <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort has no meaning here, so start+abort is just a start.
          if (start) begin
            a_q     <= data_in;
            state_q <= S_LOAD_B;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD_B: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            b_q     <= data_in;
            cnt_q   <= '0;
            state_q <= S_CMP;
          end
        end
        S_CMP: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (a_q == '0 || b_q == '0) begin
            // gcd(0,x)=x and gcd(0,0)=0, so OR of operands is the answer.
            result_q <= a_q | b_q;
            iter_q   <= cnt_q;
            zero_q   <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (a_q == b_q) begin
            result_q <= a_q;
            iter_q   <= cnt_q;
            zero_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (a_q > b_q) begin
            a_q   <= a_q - b_q;
            cnt_q <= cnt_inc_d;
          end else begin
            b_q   <= b_q - a_q;
            cnt_q <= cnt_inc_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign iter_cnt  = iter_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_gcd_seq_ctrl.sv
// Bench for gcd_seq_ctrl: directed scenarios plus randomized operations against a
// Euclid-by-division reference model (quotient sums give the subtraction count).
module tb_gcd_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] iter_cnt;
  logic        zero_flag;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_result;
  logic [15:0] last_iter;
  logic        last_zero;

  gcd_seq_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .iter_cnt (iter_cnt),
    .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: Euclid by division. Each step with nonzero remainder costs q
  // subtractions; the final step stops at equality, costing q-1.
  function automatic void gcd_model(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n,
                                    output bit z);
    int unsigned x, y, q, r;
    n = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      z = 1'b1;
      return;
    end
    z = 1'b0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    g = y;
    while (1) begin
      q = x / y;
      r = x % y;
      if (r == 0) begin
        n = n + q - 1;
        g = y;
        break;
      end
      n = n + q;
      x = y;
      y = r;
    end
    if (n > 65535) n = 65535;
  endfunction

  // Runs one operation starting at #1 after an edge while idle. hold_start keeps
  // start high throughout; repulse raises start once during CMP.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input bit hold_start, input bit repulse, input string tag);
    int unsigned eg, en;
    bit ez, seen;
    int lat;
    gcd_model(a, b, eg, en, ez);
    start   = 1'b1;
    data_in = a;
    @(posedge clk); #1;
    check({tag, "_busy_load"}, busy, 1);
    start   = hold_start;
    data_in = b;
    @(posedge clk); #1;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < int'(en) + 10) begin
      if (repulse && lat == 2) begin
        start   = 1'b1;
        data_in = 16'hDEAD;
      end else begin
        start = hold_start;
      end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, en + 2);
    check({tag, "_result"}, result, eg);
    check({tag, "_iter"}, iter_cnt, en);
    check({tag, "_zero"}, zero_flag, ez);
    last_result = result;
    last_iter   = iter_cnt;
    last_zero   = zero_flag;
    // Junk on the bus during DONE must not be taken as the next operand.
    data_in = 16'hBEEF;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;
    last_result = '0; last_iter = '0; last_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_iter", iter_cnt, 0);
    check("rst_zero", zero_flag, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(16'd12, 16'd8, 1'b0, 1'b0, "g12_8");
    do_op(16'd0, 16'd9, 1'b0, 1'b0, "g0_9");
    do_op(16'd0, 16'd0, 1'b0, 1'b0, "g0_0");
    do_op(16'd7, 16'd7, 1'b0, 1'b0, "g7_7");
    do_op(16'd100, 16'd75, 1'b0, 1'b1, "repulse");
    do_op(16'd65535, 16'd1, 1'b0, 1'b0, "g65535_1");

    // Back-to-back with start held: second A is captured in the IDLE cycle.
    do_op(16'd18, 16'd12, 1'b1, 1'b0, "b2b_first");
    do_op(16'd21, 16'd14, 1'b1, 1'b0, "b2b_second");
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Abort during CMP: no done, outputs hold.
    start = 1'b1; data_in = 16'd100;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'd75;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    begin
      bit saw_done = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);
    end
    check("abort_result_hold", result, last_result);
    check("abort_iter_hold", iter_cnt, last_iter);

    // Abort during LOAD_B.
    start = 1'b1; data_in = 16'd30;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1; data_in = 16'd6;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abortb_busy", busy, 0);
    check("abortb_result_hold", result, last_result);

    // start with abort in IDLE counts as start.
    abort = 1'b1;
    start = 1'b1; data_in = 16'd9;
    @(posedge clk); #1;
    abort = 1'b0;
    check("start_abort_busy", busy, 1);
    start = 1'b0; data_in = 16'd6;
    repeat (8) @(posedge clk);
    #1;
    check("start_abort_result", result, 3);

    // Reset in CMP clears everything.
    start = 1'b1; data_in = 16'd100;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'd75;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstcmp_busy", busy, 0);
    check("rstcmp_done", done, 0);
    check("rstcmp_result", result, 0);
    check("rstcmp_iter", iter_cnt, 0);
    check("rstcmp_zero", zero_flag, 0);
    begin
      bit saw_done = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
      end
      check("rstcmp_no_done", saw_done, 0);
    end

    // Randomized operations.
    for (int i = 0; i < 25; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
      do_op(ra, rb, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
